// File: rtl/nn_ctrl_pkg.sv
// Shared state encoding and helpers for the neural-network control blocks.
// NN_CFG_FIELD extracts per-layer field idx of width w from a packed config vector.
`define NN_CFG_FIELD(vec, idx, w) vec[(idx)*(w) +: (w)]

package nn_ctrl_pkg;

  typedef logic [3:0] nn_state_t;

  localparam nn_state_t ST_IDLE       = 4'd0;
  localparam nn_state_t ST_RAM_START  = 4'd1;
  localparam nn_state_t ST_RAM_WAIT   = 4'd2;
  localparam nn_state_t ST_SUM_TRIG   = 4'd3;
  localparam nn_state_t ST_SUM_WAIT   = 4'd4;
  localparam nn_state_t ST_OUT_SCAN   = 4'd5;
  localparam nn_state_t ST_NEXT_LAYER = 4'd6;
  localparam nn_state_t ST_DONE       = 4'd7;
  localparam nn_state_t ST_ERROR      = 4'd8;

  function automatic int nn_clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/nn_timeout_counter.sv
// Wait-state watchdog: counts enabled cycles since the last clear and flags when
// the count reaches TIMEOUT. Holds at the limit rather than wrapping.
module nn_timeout_counter #(
  parameter int TIMEOUT = 255,
  parameter int TMO_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

  logic [TMO_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_reg <= '0;
    end else if (en && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == TMO_LIMIT);

endmodule

// File: rtl/nn_layer_sequencer.sv
// Layer sequencer: per layer runs weight load, summation and a per-neuron output
// scan, with wait-state timeout (sticky error) and synchronous abort. Moore outputs.
module nn_layer_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int LAYER_W    = 2,
  parameter int SEL_W      = 3,
  parameter int TIMEOUT    = 255,
  parameter int TMO_W      = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [NUM_LAYERS*SEL_W-1:0] cfg_last,
  input  logic                        ram_done,
  input  logic                        sum_done,
  output logic                        ram_start,
  output logic                        sum_trigger,
  output logic [LAYER_W-1:0]          layer,
  output logic                        layer_sel,
  output logic [SEL_W-1:0]            output_sel,
  output logic                        out_valid,
  output logic                        busy,
  output logic                        pass_done,
  output logic                        error
);

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  nn_state_t                   state_reg, state_next;
  logic [LAYER_W-1:0]          layer_reg, layer_next;
  logic [SEL_W-1:0]            sel_reg, sel_next;
  logic [NUM_LAYERS*SEL_W-1:0] cfg_reg, cfg_next;
  logic [SEL_W-1:0]            cfg_arr [NUM_LAYERS];
  logic [SEL_W-1:0]            cur_last;
  logic                        tmo_clr, tmo_en, tmo_expired;
  logic ram_start_next, sum_trigger_next, layer_sel_next, out_valid_next;
  logic busy_next, pass_done_next, error_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_cfg
      assign cfg_arr[gi] = `NN_CFG_FIELD(cfg_reg, gi, SEL_W);
    end
  endgenerate

  always_comb begin
    cur_last = cfg_arr[0];
    for (int i = 1; i < NUM_LAYERS; i++) begin
      if (layer_reg == LAYER_W'(i)) cur_last = cfg_arr[i];
    end
  end

  // The counter is cleared in the trigger states so each wait starts from zero.
  assign tmo_clr = (state_reg == ST_RAM_START) || (state_reg == ST_SUM_TRIG);
  assign tmo_en  = (state_reg == ST_RAM_WAIT)  || (state_reg == ST_SUM_WAIT);

  nn_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .TMO_W   (TMO_W)
  ) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      layer_reg   <= '0;
      sel_reg     <= '0;
      cfg_reg     <= '0;
      ram_start   <= 1'b0;
      sum_trigger <= 1'b0;
      layer_sel   <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      pass_done   <= 1'b0;
      error       <= 1'b0;
    end else begin
      state_reg   <= state_next;
      layer_reg   <= layer_next;
      sel_reg     <= sel_next;
      cfg_reg     <= cfg_next;
      ram_start   <= ram_start_next;
      sum_trigger <= sum_trigger_next;
      layer_sel   <= layer_sel_next;
      out_valid   <= out_valid_next;
      busy        <= busy_next;
      pass_done   <= pass_done_next;
      error       <= error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    layer_next = layer_reg;
    sel_next   = sel_reg;
    cfg_next   = cfg_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RAM_START;
          cfg_next   = cfg_last;
          layer_next = '0;
        end
      end
      ST_RAM_START: state_next = ST_RAM_WAIT;
      ST_RAM_WAIT: begin
        if (ram_done)         state_next = ST_SUM_TRIG;
        else if (tmo_expired) state_next = ST_ERROR;
      end
      ST_SUM_TRIG: state_next = ST_SUM_WAIT;
      ST_SUM_WAIT: begin
        if (sum_done) begin
          state_next = ST_OUT_SCAN;
          sel_next   = '0;
        end else if (tmo_expired) begin
          state_next = ST_ERROR;
        end
      end
      ST_OUT_SCAN: begin
        if (sel_reg == cur_last) begin
          state_next = ST_NEXT_LAYER;
          sel_next   = '0;
        end else begin
          sel_next = sel_reg + 1'b1;
        end
      end
      ST_NEXT_LAYER: begin
        if (layer_reg == LAST_LAYER) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_RAM_START;
          layer_next = layer_reg + 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        layer_next = '0;
      end
      ST_ERROR: state_next = ST_ERROR;
      default: begin
        state_next = ST_IDLE;
        layer_next = '0;
        sel_next   = '0;
      end
    endcase
    if (abort) begin
      state_next = ST_IDLE;
      layer_next = '0;
      sel_next   = '0;
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    ram_start_next   = (state_next == ST_RAM_START);
    sum_trigger_next = (state_next == ST_SUM_TRIG);
    out_valid_next   = (state_next == ST_OUT_SCAN);
    pass_done_next   = (state_next == ST_DONE);
    error_next       = (state_next == ST_ERROR);
    busy_next        = (state_next != ST_IDLE) && (state_next != ST_ERROR);
    layer_sel_next   = (layer_next != '0);
  end

  assign layer      = layer_reg;
  assign output_sel = sel_reg;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench: a pass-level model queues expected events, a monitor pops and
// compares them; directed checks cover timeout, abort, reset and a 1-layer build.
module tb_nn_layer_sequencer;

  localparam int NL  = 3;
  localparam int LW  = 2;
  localparam int SW  = 3;
  localparam int TMO = 255;
  localparam int TW  = 8;
  localparam int CW  = NL * SW;
  localparam logic [CW-1:0] CFG_A = {3'd2, 3'd3, 3'd7};
  localparam int EV_RAM = 0, EV_SUM = 1, EV_OUT = 2, EV_DONE = 3;

  typedef struct {
    int kind;
    int layer;
    int sel;
  } ev_t;

  logic clk = 1'b0;
  logic reset, start, abort, ram_done, sum_done, stray_start, stray_ram;
  logic [CW-1:0] cfg_last;
  logic ram_start, sum_trigger, layer_sel, out_valid, busy, pass_done, error;
  logic [LW-1:0] layer;
  logic [SW-1:0] output_sel;
  logic [11:0] outs_vec;

  logic start1, ram_done1, sum_done1, abort1;
  logic [SW-1:0] cfg_last1;
  logic ram_start1, sum_trigger1, layer_sel1, out_valid1, busy1, pass_done1, error1;
  logic [0:0] layer1;
  logic [SW-1:0] output_sel1;

  always #5 clk = ~clk;

  nn_layer_sequencer #(
    .NUM_LAYERS(NL), .LAYER_W(LW), .SEL_W(SW), .TIMEOUT(TMO), .TMO_W(TW)
  ) dut (
    .clk(clk), .reset(reset), .start(start | stray_start), .abort(abort),
    .cfg_last(cfg_last), .ram_done(ram_done | stray_ram), .sum_done(sum_done),
    .ram_start(ram_start), .sum_trigger(sum_trigger), .layer(layer),
    .layer_sel(layer_sel), .output_sel(output_sel), .out_valid(out_valid),
    .busy(busy), .pass_done(pass_done), .error(error)
  );

  nn_layer_sequencer #(
    .NUM_LAYERS(1), .LAYER_W(1), .SEL_W(SW), .TIMEOUT(TMO), .TMO_W(TW)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .cfg_last(cfg_last1), .ram_done(ram_done1), .sum_done(sum_done1),
    .ram_start(ram_start1), .sum_trigger(sum_trigger1), .layer(layer1),
    .layer_sel(layer_sel1), .output_sel(output_sel1), .out_valid(out_valid1),
    .busy(busy1), .pass_done(pass_done1), .error(error1)
  );

  assign outs_vec = {ram_start, sum_trigger, layer, layer_sel, output_sel,
                     out_valid, busy, pass_done, error};

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  ev_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: the full event sequence of one pass, from the layer configuration.
  task automatic push_pass(input logic [CW-1:0] cfg);
    for (int l = 0; l < NL; l++) begin
      int last;
      last = int'(cfg[l*SW +: SW]);
      exp_q.push_back('{EV_RAM, l, 0});
      exp_q.push_back('{EV_SUM, l, 0});
      for (int s = 0; s <= last; s++) exp_q.push_back('{EV_OUT, l, s});
    end
    exp_q.push_back('{EV_DONE, 0, 0});
  endtask

  // Monitor
  int npulse, kind, ram_start_cyc, ram_seen, done_seen;
  int ov_seen [NL];
  int ram_fire_cyc, sum_fire_cyc;
  ev_t cur;

  initial begin
    ram_seen = 0; done_seen = 0; ram_start_cyc = 0;
    for (int i = 0; i < NL; i++) ov_seen[i] = 0;
  end

  always @(negedge clk) begin
    if (!reset) begin
      npulse = int'(ram_start) + int'(sum_trigger) + int'(out_valid) + int'(pass_done);
      if (npulse > 1) check("one_pulse_at_a_time", npulse, 1);
      if (!out_valid) check("output_sel_zero_when_idle", int'(output_sel), 0);
      check("layer_sel_tracks_layer", int'(layer_sel), int'(layer != '0));
      if (npulse == 1) begin
        kind = ram_start ? EV_RAM : sum_trigger ? EV_SUM : out_valid ? EV_OUT : EV_DONE;
        if (kind == EV_RAM) begin ram_seen++; ram_start_cyc = cyc; end
        if (kind == EV_OUT) ov_seen[layer]++;
        if (kind == EV_DONE) done_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_event", kind, -1);
        end else begin
          cur = exp_q.pop_front();
          check("event_kind", kind, cur.kind);
          if (kind != EV_DONE) check("event_layer", int'(layer), cur.layer);
          if (kind == EV_OUT) check("event_output_sel", int'(output_sel), cur.sel);
          if (kind == EV_SUM) check("ram_done_to_sum_trigger", cyc - ram_fire_cyc, 1);
          if (kind == EV_OUT && cur.sel == 0)
            check("sum_done_to_out_valid", cyc - sum_fire_cyc, 1);
        end
      end
    end
  end

  // Responder: pulses ram_done / sum_done a set number of cycles after each trigger.
  int ram_delay = 1, sum_delay = 1, ram_cnt = 0, sum_cnt = 0, stray_cnt = 0;
  bit stray_en = 1'b0;

  initial begin
    ram_done = 0; sum_done = 0; stray_start = 0; stray_ram = 0;
    ram_fire_cyc = 0; sum_fire_cyc = 0;
    forever begin
      @(posedge clk); #1;
      ram_done = 0; sum_done = 0; stray_start = 0; stray_ram = 0;
      if (!busy) begin ram_cnt = 0; sum_cnt = 0; stray_cnt = 0; end
      if (ram_cnt > 0) begin
        ram_cnt--;
        if (ram_cnt == 0) begin ram_done = 1; ram_fire_cyc = cyc; end
      end
      if (sum_cnt > 0) begin
        sum_cnt--;
        if (sum_cnt == 0) begin sum_done = 1; sum_fire_cyc = cyc; end
      end
      if (stray_cnt > 0) begin
        stray_cnt--;
        if (stray_cnt == 0) begin stray_start = 1; stray_ram = 1; end
      end
      if (ram_start && ram_delay > 0) ram_cnt = ram_delay;
      if (sum_trigger && sum_delay > 0) begin
        sum_cnt = sum_delay;
        if (stray_en) stray_cnt = 2;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int got;

  task automatic run_pass(input logic [CW-1:0] cfg, input logic [CW-1:0] cfg_mid);
    cfg_last = cfg;
    push_pass(cfg);
    start = 1; tick(1); start = 0;
    check("start_to_ram_start", int'(ram_start), 1);
    cfg_last = cfg_mid;
    got = 0;
    for (int i = 0; i < 3000; i++) begin
      if (pass_done) begin got = 1; break; end
      tick(1);
    end
    check("pass_done_reached", got, 1);
    tick(1);
    check("busy_after_pass", int'(busy), 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] pass cfg=%03h done at cycle %0d, tests=%0d", cfg, cyc, tests);
  endtask

  int r0, d0;
  int o0 [NL];

  initial begin
    reset = 1; start = 0; abort = 0; cfg_last = '0;
    start1 = 0; abort1 = 0; cfg_last1 = '0; ram_done1 = 1; sum_done1 = 1;
    tick(3);
    reset = 0;
    check("reset_outputs", int'(outs_vec), 0);

    // Directed pass: cfg {2,3,7}, done 2 cycles after each trigger
    ram_delay = 2; sum_delay = 2;
    r0 = ram_seen; d0 = done_seen;
    for (int i = 0; i < NL; i++) o0[i] = ov_seen[i];
    run_pass(CFG_A, CFG_A);
    check("ram_start_count", ram_seen - r0, 3);
    check("out_valid_layer0", ov_seen[0] - o0[0], 8);
    check("out_valid_layer1", ov_seen[1] - o0[1], 4);
    check("out_valid_layer2", ov_seen[2] - o0[2], 3);
    check("pass_done_count", done_seen - d0, 1);

    // Random passes with cfg changed mid-pass
    for (int p = 0; p < 8; p++) begin
      ram_delay = int'($urandom_range(1, 6));
      sum_delay = int'($urandom_range(1, 6));
      run_pass(CW'($urandom), CW'($urandom));
    end

    // Stray start and ram_done during SUM_WAIT
    stray_en = 1; sum_delay = 4; ram_delay = 2;
    run_pass(CFG_A, CFG_A);
    stray_en = 0;

    // sum_done on the cycle the timeout is reached: done wins
    ram_delay = 1; sum_delay = TMO + 1;
    run_pass('0, '0);
    check("done_wins_no_error", int'(error), 0);

    // RAM_WAIT timeout
    ram_delay = 0; sum_delay = 2;
    cfg_last = CFG_A; push_pass(CFG_A);
    start = 1; tick(1); start = 0;
    got = 0;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (error) begin got = 1; break; end
    end
    check("timeout_reached", got, 1);
    check("timeout_cycles_from_ram_wait", cyc - ram_start_cyc - 1, TMO + 1);
    check("busy_in_error", int'(busy), 0);
    tick(20);
    check("error_sticky", int'(error), 1);
    abort = 1; tick(1); abort = 0;
    exp_q.delete();
    check("abort_clears_error", int'(outs_vec), 0);
    $display("[TB] timeout/abort checked at cycle %0d", cyc);

    // Abort during layer 1 OUT_SCAN at output_sel=2
    ram_delay = 2; sum_delay = 2;
    cfg_last = CFG_A; push_pass(CFG_A); d0 = done_seen;
    start = 1; tick(1); start = 0;
    got = 0;
    for (int i = 0; i < 600; i++) begin
      tick(1);
      if (out_valid && layer == 2'd1 && output_sel == 3'd2) begin got = 1; break; end
    end
    check("abort_point_reached", got, 1);
    abort = 1; tick(1); abort = 0;
    exp_q.delete();
    check("abort_outputs_zero", int'(outs_vec), 0);
    tick(5);
    check("abort_no_pass_done", done_seen - d0, 0);
    run_pass(CFG_A, CW'($urandom));

    // Reset mid-pass
    cfg_last = CFG_A; push_pass(CFG_A); d0 = done_seen;
    start = 1; tick(1); start = 0;
    tick(6);
    reset = 1; tick(1); reset = 0;
    exp_q.delete();
    check("reset_midpass_outputs", int'(outs_vec), 0);
    tick(5);
    check("reset_midpass_no_done", done_seen - d0, 0);
    check("reset_midpass_idle", int'(busy), 0);

    // Single-layer build, start held high: back-to-back passes of 8 cycles
    start1 = 1;
    for (int k = 1; k <= 16; k++) begin
      int exp_mask;
      tick(1);
      exp_mask = 0;
      if (k % 8 == 1) exp_mask = 8;
      if (k % 8 == 3) exp_mask = 4;
      if (k % 8 == 5) exp_mask = 2;
      if (k % 8 == 7) exp_mask = 1;
      check("one_layer_cycle", int'({ram_start1, sum_trigger1, out_valid1, pass_done1}), exp_mask);
      check("one_layer_sel", int'(output_sel1), 0);
      $display("[TB] one-layer cycle %0d events=%04b", k,
               {ram_start1, sum_trigger1, out_valid1, pass_done1});
    end
    start1 = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
